// File: rtl/udp_rx_pkg.sv
// Shared types and constants for the UDP receive payload buffer.
package udp_rx_pkg;

    localparam logic [15:0] UDP_HDR_BYTES = 16'd8;
    localparam logic [15:0] CSUM_GOOD     = 16'hFFFF;
    // Descriptor word count is sized for the largest supported RAM (ADDR_W <= 15).
    localparam int          WORDS_W       = 16;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_FETCH,
        RD_STREAM
    } rd_state_t;

    typedef struct packed {
        logic [15:0]        byte_len;
        logic [WORDS_W-1:0] words;
    } udp_desc_t;

    function automatic logic [2:0] last_bytes(input logic [1:0] len_lo);
        return (len_lo == 2'd0) ? 3'd4 : {1'b0, len_lo};
    endfunction

endpackage

// File: rtl/udp_rx_buffer_if.sv
// Transport-side payload stream in, packet stream out.
interface udp_rx_buffer_if;

    logic        in_op_st;
    logic        in_op;
    logic        in_op_end;
    logic [31:0] in_data;
    logic [15:0] crc_sum;
    logic [15:0] udp_checksum;
    logic [15:0] packet_length;
    logic [15:0] dest_port;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic [2:0]  out_last_bytes;

    modport master (
        output in_op_st, in_op, in_op_end, in_data,
               crc_sum, udp_checksum, packet_length, dest_port, out_ready,
        input  out_valid, out_data, out_sop, out_eop, out_last_bytes
    );

    modport slave (
        input  in_op_st, in_op, in_op_end, in_data,
               crc_sum, udp_checksum, packet_length, dest_port, out_ready,
        output out_valid, out_data, out_sop, out_eop, out_last_bytes
    );

endinterface

// File: rtl/udp_rx_dpram.sv
// Simple dual-port RAM: one write port, one synchronous read port with registered data.
module udp_rx_dpram #(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [1<<AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/udp_rx_buffer.sv
// UDP payload buffer: commit/rewind write side, descriptor FIFO, packet read FSM.
// Optional destination-port filter: define UDP_PORT_FILTER_EN.
module udp_rx_buffer
    import udp_rx_pkg::*;
#(
    parameter int          ADDR_W     = 9,
    parameter int          DESC_AW    = 3,
    parameter logic [15:0] LOCAL_PORT = 16'd5000
) (
    input  logic             clk,
    input  logic             rst_n,
    udp_rx_buffer_if.slave   io,
    output logic [15:0]      pkt_ok_cnt,
    output logic [15:0]      drop_csum_cnt,
    output logic [15:0]      drop_ovf_cnt
);

    typedef logic [ADDR_W:0] ptr_t;

    ptr_t      wr_ptr, commit_ptr, rd_ptr, base_ptr, wr_next, used, rd_addr;
    logic      open, ovf, open_eff, ovf_next, ram_we, fin, commit;
    logic      csum_ok, port_ok, missing_end, drop_ovf, drop_csum;
    logic      desc_full, desc_empty, pop, ram_re, accept, last;
    logic [31:0] ram_q;
    udp_desc_t desc_rd;
    udp_desc_t desc_mem [1<<DESC_AW];
    logic [DESC_AW:0] dw_ptr, dr_ptr;
    rd_state_t state, state_n;

    ptr_t        cur_rem;
    logic [2:0]  cur_lb;
    logic        o_valid, o_sop, o_eop;
    logic [31:0] o_data;
    logic [2:0]  o_lb;

`ifdef UDP_PORT_FILTER_EN
    assign port_ok = (io.dest_port == LOCAL_PORT);
`else
    assign port_ok = 1'b1;
`endif

    logic unused_bits;
    assign unused_bits = ^{desc_rd, io.dest_port, rd_addr[ADDR_W]};

    // A start always rebases on commit_ptr, which also rewinds a packet that never ended.
    always_comb begin
        base_ptr    = io.in_op_st ? commit_ptr : wr_ptr;
        open_eff    = io.in_op_st | open;
        used        = base_ptr - rd_ptr;
        ram_we      = io.in_op & open_eff & ~used[ADDR_W];
        ovf_next    = (ovf & ~io.in_op_st) | (io.in_op & open_eff & used[ADDR_W]);
        wr_next     = base_ptr + ptr_t'(ram_we);
        fin         = io.in_op_end & open_eff;
        missing_end = io.in_op_st & open;
        csum_ok     = (io.udp_checksum == 16'h0000) | (io.crc_sum == CSUM_GOOD);
        commit      = fin & csum_ok & ~ovf_next & ~desc_full & port_ok;
        drop_ovf    = fin & port_ok & (ovf_next | desc_full);
        drop_csum   = fin & port_ok & ~(ovf_next | desc_full) & ~csum_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            commit_ptr    <= '0;
            open          <= 1'b0;
            ovf           <= 1'b0;
            pkt_ok_cnt    <= '0;
            drop_csum_cnt <= '0;
            drop_ovf_cnt  <= '0;
        end else begin
            open          <= open_eff & ~fin;
            ovf           <= ovf_next;
            wr_ptr        <= (fin & ~commit) ? commit_ptr : wr_next;
            if (commit) commit_ptr <= wr_next;
            pkt_ok_cnt    <= pkt_ok_cnt + 16'(commit);
            drop_csum_cnt <= drop_csum_cnt + 16'(drop_csum);
            drop_ovf_cnt  <= drop_ovf_cnt + 16'(missing_end) + 16'(drop_ovf);
        end
    end

    assign desc_empty = (dw_ptr == dr_ptr);
    assign desc_full  = (dw_ptr[DESC_AW] != dr_ptr[DESC_AW]) &&
                        (dw_ptr[DESC_AW-1:0] == dr_ptr[DESC_AW-1:0]);
    assign desc_rd    = desc_mem[dr_ptr[DESC_AW-1:0]];

    always_ff @(posedge clk) begin
        if (commit)
            desc_mem[dw_ptr[DESC_AW-1:0]] <= '{byte_len: io.packet_length - UDP_HDR_BYTES,
                                              words:    WORDS_W'(wr_next - commit_ptr)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dw_ptr <= '0;
            dr_ptr <= '0;
        end else begin
            if (commit) dw_ptr <= dw_ptr + 1'b1;
            if (pop)    dr_ptr <= dr_ptr + 1'b1;
        end
    end

    udp_rx_dpram #(.AW(ADDR_W), .DW(32)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (base_ptr[ADDR_W-1:0]),
        .wdata (io.in_data),
        .re    (ram_re),
        .raddr (rd_addr[ADDR_W-1:0]),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RD_IDLE;
        else        state <= state_n;
    end

    // ram_q always holds the word after the one in the output register.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        ram_re  = 1'b0;
        rd_addr = rd_ptr;
        accept  = o_valid & io.out_ready;
        last    = (cur_rem == ptr_t'(1));
        case (state)
            RD_IDLE: if (!desc_empty) begin
                pop     = 1'b1;
                ram_re  = 1'b1;
                state_n = RD_FETCH;
            end
            RD_FETCH: begin
                ram_re  = 1'b1;
                rd_addr = rd_ptr + ptr_t'(1);
                state_n = RD_STREAM;
            end
            RD_STREAM: if (accept) begin
                if (!last) begin
                    ram_re  = 1'b1;
                    rd_addr = rd_ptr + ptr_t'(2);
                end else if (!desc_empty) begin
                    pop     = 1'b1;
                    ram_re  = 1'b1;
                    rd_addr = rd_ptr + ptr_t'(1);
                    state_n = RD_FETCH;
                end else begin
                    state_n = RD_IDLE;
                end
            end
            default: state_n = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            cur_rem <= '0;
            cur_lb  <= '0;
            o_valid <= 1'b0;
            o_sop   <= 1'b0;
            o_eop   <= 1'b0;
            o_lb    <= '0;
            o_data  <= '0;
        end else begin
            if (pop) begin
                cur_rem <= desc_rd.words[ADDR_W:0];
                cur_lb  <= last_bytes(desc_rd.byte_len[1:0]);
            end
            if (state == RD_FETCH) begin
                o_valid <= 1'b1;
                o_sop   <= 1'b1;
                o_data  <= ram_q;
                o_eop   <= last;
                o_lb    <= last ? cur_lb : 3'd0;
            end else if (state == RD_STREAM && accept) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
                o_sop  <= 1'b0;
                if (!last) begin
                    cur_rem <= cur_rem - ptr_t'(1);
                    o_data  <= ram_q;
                    o_eop   <= (cur_rem == ptr_t'(2));
                    o_lb    <= (cur_rem == ptr_t'(2)) ? cur_lb : 3'd0;
                end else begin
                    o_valid <= 1'b0;
                    o_eop   <= 1'b0;
                    o_lb    <= 3'd0;
                end
            end
        end
    end

    assign io.out_valid      = o_valid;
    assign io.out_data       = o_data;
    assign io.out_sop        = o_sop;
    assign io.out_eop        = o_eop;
    assign io.out_last_bytes = o_lb;

endmodule

// File: tb/tb_udp_rx_buffer.sv
// Self-checking bench for udp_rx_buffer: directed table, corner sequences, randomized packets.
module tb_udp_rx_buffer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] pkt_ok_cnt, drop_csum_cnt, drop_ovf_cnt;

    udp_rx_buffer_if bus();

    udp_rx_buffer #(.ADDR_W(4), .DESC_AW(3), .LOCAL_PORT(16'd5000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .io            (bus),
        .pkt_ok_cnt    (pkt_ok_cnt),
        .drop_csum_cnt (drop_csum_cnt),
        .drop_ovf_cnt  (drop_ovf_cnt)
    );

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  lb;
    } exp_t;

    typedef struct {
        int          nbytes;
        logic [15:0] crc;
        logic [15:0] csum;
        int          kind;   // 0 delivered, 1 checksum drop, 2 overflow drop
        int          nw;
        logic [2:0]  lb;
    } vec_t;

    exp_t        sb[$];
    logic [31:0] pkt_words[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          ready_mode = 0;
    logic [15:0] e_ok = 0, e_csum = 0, e_ovf = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Consumer: 0 always ready, 1 random, 2 alternating, 3 stalled.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                2:       bus.out_ready = ~bus.out_ready;
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Output monitor: scoreboard compare on accept, stability while stalled.
    initial begin
        bit          held;
        logic [37:0] snap, cur;
        exp_t        e;
        held = 0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 0;
                continue;
            end
            cur = {bus.out_valid, bus.out_data, bus.out_sop, bus.out_eop, bus.out_last_bytes};
            if (held) chk("hold_stable", 64'(cur), 64'(snap));
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %h, expected no word", bus.out_data);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", 64'(bus.out_data), 64'(e.data));
                    chk("out_sop", 64'(bus.out_sop), 64'(e.sop));
                    chk("out_eop", 64'(bus.out_eop), 64'(e.eop));
                    chk("out_last_bytes", 64'(bus.out_last_bytes), 64'(e.lb));
                end
            end
            held = bus.out_valid && !bus.out_ready;
            snap = cur;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected to finish");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        bus.in_op_st = 0; bus.in_op = 0; bus.in_op_end = 0; bus.in_data = '0;
        bus.crc_sum = '0; bus.udp_checksum = '0; bus.packet_length = '0; bus.dest_port = 16'd5000;
    endtask

    task automatic gen_pkt(input int nw);
        pkt_words.delete();
        for (int i = 0; i < nw; i++) pkt_words.push_back($urandom);
    endtask

    task automatic expect_pkt(input int nw, input logic [2:0] lb);
        for (int i = 0; i < nw; i++)
            sb.push_back('{data: pkt_words[i], sop: (i == 0), eop: (i == nw - 1),
                           lb: (i == nw - 1) ? lb : 3'd0});
    endtask

    function automatic logic [2:0] model_lb(input int nbytes);
        return (nbytes % 4 == 0) ? 3'd4 : 3'(nbytes % 4);
    endfunction

    task automatic send_pkt(input int nbytes, input logic [15:0] crc, input logic [15:0] csum,
                            input bit sep_end, input bit no_end);
        int nw;
        nw = (nbytes + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            @(posedge clk); #1;
            bus.in_op_st      = (i == 0);
            bus.in_op         = 1'b1;
            bus.in_data       = pkt_words[i];
            bus.in_op_end     = (i == nw - 1) && !sep_end && !no_end;
            bus.packet_length = 16'(nbytes + 8);
            bus.crc_sum       = crc;
            bus.udp_checksum  = csum;
        end
        if (sep_end && !no_end) begin
            @(posedge clk); #1;
            bus.in_op_st = 0; bus.in_op = 0; bus.in_op_end = 1;
        end
        @(posedge clk); #1;
        drive_idle();
    endtask

    task automatic wait_sb(input int left, input string name);
        int budget;
        budget = 2000;
        while (sb.size() > left && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        n_tests++;
        if (sb.size() > left) begin
            n_fail++;
            $display("FAIL %s: %0d words pending, required at most %0d", name, sb.size(), left);
            sb.delete();
        end
    endtask

    task automatic check_cnts(input string tag);
        repeat (3) @(negedge clk);
        chk({tag, "_pkt_ok_cnt"}, 64'(pkt_ok_cnt), 64'(e_ok));
        chk({tag, "_drop_csum_cnt"}, 64'(drop_csum_cnt), 64'(e_csum));
        chk({tag, "_drop_ovf_cnt"}, 64'(drop_ovf_cnt), 64'(e_ovf));
    endtask

    initial begin
        vec_t vt[5];
        vt[0] = '{12, 16'hFFFF, 16'hABCD, 0, 3, 3'd4};
        vt[1] = '{12, 16'hFFFE, 16'h1234, 1, 0, 3'd0};
        vt[2] = '{ 5, 16'h0F0F, 16'h0000, 0, 2, 3'd1};
        vt[3] = '{80, 16'hFFFF, 16'h5555, 2, 0, 3'd0};
        vt[4] = '{ 8, 16'hFFFF, 16'h2222, 0, 2, 3'd4};

        drive_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 0);
        chk("rst_out_last_bytes", 64'(bus.out_last_bytes), 0);
        chk("rst_pkt_ok_cnt", 64'(pkt_ok_cnt), 0);
        chk("rst_drop_ovf_cnt", 64'(drop_ovf_cnt), 0);
        #1 rst_n = 1'b1;

        ready_mode = 0;
        for (int v = 0; v < 5; v++) begin
            gen_pkt((vt[v].nbytes + 3) / 4);
            if (vt[v].kind == 0) begin
                expect_pkt(vt[v].nw, vt[v].lb);
                e_ok++;
            end else if (vt[v].kind == 1) e_csum++;
            else e_ovf++;
            send_pkt(vt[v].nbytes, vt[v].crc, vt[v].csum, 0, 0);
            wait_sb(0, "vec_drain");
            check_cnts("vec");
        end

        // Stray word and stray end while no packet is open, then a split-end packet.
        @(posedge clk); #1;
        bus.in_op = 1; bus.in_data = 32'hDEADBEEF;
        @(posedge clk); #1;
        bus.in_op = 0; bus.in_op_end = 1; bus.crc_sum = 16'hFFFF;
        @(posedge clk); #1;
        drive_idle();
        gen_pkt(3); expect_pkt(3, model_lb(10)); e_ok++;
        send_pkt(10, 16'hFFFF, 16'h7777, 1, 0);
        wait_sb(0, "stray_drain");
        check_cnts("stray");

        // Missing end: the restart rewinds and counts an overflow drop.
        gen_pkt(3);
        send_pkt(12, 16'hFFFF, 16'h1111, 0, 1);
        e_ovf++;
        gen_pkt(2); expect_pkt(2, model_lb(7)); e_ok++;
        send_pkt(7, 16'hFFFF, 16'h1111, 0, 0);
        wait_sb(0, "noend_drain");
        check_cnts("noend");

        // Back-to-back packets against an alternating consumer.
        ready_mode = 2;
        gen_pkt(5); expect_pkt(5, 3'd4); e_ok++;
        send_pkt(20, 16'hFFFF, 16'h3333, 0, 0);
        gen_pkt(5); expect_pkt(5, 3'd4); e_ok++;
        send_pkt(20, 16'h0123, 16'h0000, 0, 0);
        wait_sb(0, "b2b_drain");
        check_cnts("b2b");

        // Descriptor FIFO full: one packet in the reader plus eight queued; the tenth drops.
        ready_mode = 3;
        repeat (2) @(posedge clk);
        for (int p = 0; p < 10; p++) begin
            gen_pkt(1);
            if (p < 9) begin
                expect_pkt(1, 3'd4);
                e_ok++;
            end else e_ovf++;
            send_pkt(4, 16'hFFFF, 16'h4444, 0, 0);
        end
        ready_mode = 0;
        wait_sb(0, "descfull_drain");
        check_cnts("descfull");

        // Reset in the middle of a six-word packet.
        gen_pkt(6);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus.in_op_st = (i == 0); bus.in_op = 1; bus.in_data = pkt_words[i];
            bus.packet_length = 16'd32;
        end
        @(posedge clk); #1;
        drive_idle();
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_out_valid", 64'(bus.out_valid), 0);
        chk("mrst_out_sop", 64'(bus.out_sop), 0);
        chk("mrst_out_eop", 64'(bus.out_eop), 0);
        chk("mrst_out_data", 64'(bus.out_data), 0);
        chk("mrst_out_last_bytes", 64'(bus.out_last_bytes), 0);
        chk("mrst_pkt_ok_cnt", 64'(pkt_ok_cnt), 0);
        chk("mrst_drop_csum_cnt", 64'(drop_csum_cnt), 0);
        chk("mrst_drop_ovf_cnt", 64'(drop_ovf_cnt), 0);
        sb.delete();
        e_ok = 0; e_csum = 0; e_ovf = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        gen_pkt(4); expect_pkt(4, 3'd4); e_ok++;
        send_pkt(16, 16'hFFFF, 16'h9999, 0, 0);
        wait_sb(0, "mrst_drain");
        check_cnts("mrst");

        // Randomized packets against the checksum-rule model.
        ready_mode = 1;
        for (int p = 0; p < 40; p++) begin
            int          nb;
            int          sel;
            logic [15:0] crc, csum;
            wait_sb(6, "rand_gate");
            nb  = $urandom_range(1, 24);
            sel = $urandom_range(0, 2);
            crc  = 16'($urandom);
            csum = 16'($urandom_range(1, 16'hFFFF));
            if (sel == 0) csum = 16'h0000;
            else if (sel == 1) crc = 16'hFFFF;
            else crc = crc & 16'hFFFE;
            gen_pkt((nb + 3) / 4);
            if (csum == 16'h0000 || crc == 16'hFFFF) begin
                expect_pkt((nb + 3) / 4, model_lb(nb));
                e_ok++;
            end else e_csum++;
            send_pkt(nb, crc, csum, 1'($urandom_range(0, 1)), 0);
        end
        wait_sb(0, "rand_drain");
        check_cnts("rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
